// File: rtl/cordic_post_scale_pkg.sv
// Shared constants for the CORDIC post-scale stage: default widths, the 1/K shift-add list
// and the pi phase constant.
package cordic_post_scale_pkg;

  localparam int unsigned DEF_WORD_WIDTH  = 16;
  localparam int unsigned DEF_PHASE_WIDTH = 16;
  localparam int unsigned DEF_ITERATIONS  = 16;
  localparam int unsigned DEF_GUARD_BITS  = 16;

  // 1/K ~= 2^-1 + 2^-3 - 2^-6 - 2^-9 - 2^-12 + 2^-14 + 2^-16 = 0.60725403
  localparam int unsigned INVK_SH_P1  = 1;
  localparam int unsigned INVK_SH_P3  = 3;
  localparam int unsigned INVK_SH_N6  = 6;
  localparam int unsigned INVK_SH_N9  = 9;
  localparam int unsigned INVK_SH_N12 = 12;
  localparam int unsigned INVK_SH_P14 = 14;
  localparam int unsigned INVK_SH_P16 = 16;

  // Phase code for pi: 2^(phase_width-1), the half-scale point of the phase circle.
  function automatic logic [31:0] phase_pi(input int unsigned phase_width);
    return 32'd1 << (phase_width - 1);
  endfunction

endpackage

// File: rtl/cordic_post_scale_delay_line.sv
// Fixed-depth shift register with async active-low reset. The MSB of each word is treated
// as a valid flag; any_vld reports whether any stage currently holds one.
module cordic_post_scale_delay_line #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             any_vld
);

  logic [DEPTH-1:0][WIDTH-1:0] sr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q <= '0;
    end else begin
      sr_q[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  always_comb begin
    any_vld = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      any_vld = any_vld | sr_q[i][WIDTH-1];
    end
  end

  assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/cordic_post_scale.sv
// CORDIC post-scale: removes the CORDIC gain from x with a shift-add network and
// quadrant-corrects z. Define CORDIC_POST_SCALE_ROUND_EN for round-half-up on the magnitude.
module cordic_post_scale
  import cordic_post_scale_pkg::*;
#(
  parameter int unsigned WORD_WIDTH  = DEF_WORD_WIDTH,
  parameter int unsigned PHASE_WIDTH = DEF_PHASE_WIDTH,
  parameter int unsigned ITERATIONS  = DEF_ITERATIONS,
  parameter int unsigned GUARD_BITS  = DEF_GUARD_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   vld_in,
  input  logic                   flip_in,
  input  logic [WORD_WIDTH-1:0]  x_in,
  input  logic [PHASE_WIDTH-1:0] z_in,
  output logic [WORD_WIDTH-1:0]  mag_out,
  output logic [PHASE_WIDTH-1:0] phase_out,
  output logic                   out_valid,
  output logic                   busy
);

  localparam int unsigned ACC_WIDTH = WORD_WIDTH + GUARD_BITS + 1;
  localparam logic [PHASE_WIDTH-1:0] PHASE_PI = PHASE_WIDTH'(phase_pi(PHASE_WIDTH));
`ifdef CORDIC_POST_SCALE_ROUND_EN
  localparam logic signed [ACC_WIDTH-1:0] ROUND_HALF = ACC_WIDTH'(1) << (GUARD_BITS - 1);
`endif

  // Entry-side {vld, flip} travels alongside the rotator chain.
  logic [1:0] dly_tap;
  logic       dly_any;
  logic       dly_vld;
  logic       dly_flip;

  cordic_post_scale_delay_line #(
    .WIDTH (2),
    .DEPTH (ITERATIONS)
  ) u_delay_line (
    .clk     (clk),
    .rst     (rst),
    .din     ({vld_in, flip_in}),
    .dout    (dly_tap),
    .any_vld (dly_any)
  );

  assign dly_vld  = dly_tap[1];
  assign dly_flip = dly_tap[0];

  // Stage A
  logic [WORD_WIDTH-1:0]         x_pos;
  logic signed [ACC_WIDTH-1:0]   xa_d, pa_d;
  logic signed [ACC_WIDTH-1:0]   xa_q, pa_q;
  logic [PHASE_WIDTH-1:0]        za_q;
  logic                          flipa_q, vlda_q;

  // Negative x is a rounding artefact of the rotators; treat it as zero magnitude.
  assign x_pos = x_in[WORD_WIDTH-1] ? '0 : x_in;
  assign xa_d  = $signed({x_pos[WORD_WIDTH-1], x_pos, {GUARD_BITS{1'b0}}});
  assign pa_d  = (xa_d >>> INVK_SH_P1) + (xa_d >>> INVK_SH_P3) - (xa_d >>> INVK_SH_N6);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xa_q    <= '0;
      pa_q    <= '0;
      za_q    <= '0;
      flipa_q <= 1'b0;
      vlda_q  <= 1'b0;
    end else begin
      vlda_q <= dly_vld;
      if (dly_vld) begin
        xa_q    <= xa_d;
        pa_q    <= pa_d;
        za_q    <= z_in;
        flipa_q <= dly_flip;
      end
    end
  end

  // Stage B, folded into the output register
  logic signed [ACC_WIDTH-1:0] acc, acc_rnd;
  logic [WORD_WIDTH-1:0]       mag_d;
  logic [PHASE_WIDTH-1:0]      phase_d;
  logic                        unused_acc;

  always_comb begin
    acc = pa_q - (xa_q >>> INVK_SH_N9) - (xa_q >>> INVK_SH_N12)
               + (xa_q >>> INVK_SH_P14) + (xa_q >>> INVK_SH_P16);
`ifdef CORDIC_POST_SCALE_ROUND_EN
    acc_rnd = acc + ROUND_HALF;
`else
    acc_rnd = acc;
`endif
  end

  assign mag_d      = acc_rnd[GUARD_BITS +: WORD_WIDTH];
  assign unused_acc = ^{acc_rnd[GUARD_BITS-1:0], acc_rnd[ACC_WIDTH-1]};
  // Adding pi wraps naturally modulo the phase width.
  assign phase_d    = za_q + (flipa_q ? PHASE_PI : '0);

  logic [WORD_WIDTH-1:0]  mag_q;
  logic [PHASE_WIDTH-1:0] phase_q;
  logic                   out_valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mag_q       <= '0;
      phase_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= vlda_q;
      if (vlda_q) begin
        mag_q   <= mag_d;
        phase_q <= phase_d;
      end
    end
  end

  assign mag_out   = mag_q;
  assign phase_out = phase_q;
  assign out_valid = out_valid_q;
  assign busy      = dly_any | vlda_q | out_valid_q;

endmodule

// File: tb/tb_cordic_post_scale.sv
// Self-checking bench for cordic_post_scale: table vectors, a ramp, random traffic against a
// cycle-indexed reference model, and an asynchronous reset mid-stream.
module tb_cordic_post_scale;

  localparam int ITER = 16;
  localparam int LAT  = ITER + 2;
  localparam int NC   = 320;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld_in, flip_in;
  logic [15:0] x_in, z_in;
  logic [15:0] mag_out, phase_out;
  logic        out_valid, busy;

  cordic_post_scale #(
    .WORD_WIDTH  (16),
    .PHASE_WIDTH (16),
    .ITERATIONS  (ITER),
    .GUARD_BITS  (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .vld_in    (vld_in),
    .flip_in   (flip_in),
    .x_in      (x_in),
    .z_in      (z_in),
    .mag_out   (mag_out),
    .phase_out (phase_out),
    .out_valid (out_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Cycle-indexed plan: what is driven in each cycle and what must be visible in each cycle.
  logic        plan_vld [NC];
  logic        plan_flip[NC];
  logic        has_dat  [NC];
  logic [15:0] dat_x    [NC];
  logic [15:0] dat_z    [NC];
  logic        exp_v    [NC];
  logic [15:0] exp_m    [NC];
  logic [15:0] exp_p    [NC];

  int          cyc;
  int          n_checks;
  int          n_fail;
  logic [15:0] held_m, held_p;

  typedef struct {
    logic        flip;
    logic [15:0] x;
    logic [15:0] z;
    logic [15:0] mag;
    logic [15:0] phase;
  } vec_t;

  vec_t tbl[6];

  // 1/K as an exact fraction of 2^16 from the shift list.
  function automatic logic [15:0] ref_mag(input logic [15:0] x);
    longint coef;
    longint prod;
    coef = (1 << 15) + (1 << 13) - (1 << 10) - (1 << 7) - (1 << 4) + (1 << 2) + 1;
    if (x[15]) return 16'd0;
    prod = longint'(x) * coef;
`ifdef CORDIC_POST_SCALE_ROUND_EN
    prod = prod + 32768;
`endif
    return 16'(prod / 65536);
  endfunction

  function automatic logic [15:0] ref_phase(input logic [15:0] z, input logic fl);
    int unsigned s;
    s = int'(z) + (fl ? 32768 : 0);
    return 16'(s % 65536);
  endfunction

  task automatic clear_plan();
    for (int i = 0; i < NC; i++) begin
      plan_vld[i]  = 1'b0;
      plan_flip[i] = 1'b0;
      has_dat[i]   = 1'b0;
      dat_x[i]     = '0;
      dat_z[i]     = '0;
      exp_v[i]     = 1'b0;
      exp_m[i]     = '0;
      exp_p[i]     = '0;
    end
  endtask

  task automatic sched(input int c, input logic fl, input logic [15:0] x, input logic [15:0] z,
                       input logic [15:0] m, input logic [15:0] p);
    plan_vld[c]     = 1'b1;
    plan_flip[c]    = fl;
    has_dat[c+ITER] = 1'b1;
    dat_x[c+ITER]   = x;
    dat_z[c+ITER]   = z;
    exp_v[c+LAT]    = 1'b1;
    exp_m[c+LAT]    = m;
    exp_p[c+LAT]    = p;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h, required %0h", name, cyc, act, req);
    end
  endtask

  // Called #1 after an edge: compare the outputs of the previous edge, then drive this cycle.
  task automatic run_until(input int last);
    logic exp_busy;
    while (cyc < last) begin
      if (exp_v[cyc]) begin
        held_m = exp_m[cyc];
        held_p = exp_p[cyc];
      end
      exp_busy = 1'b0;
      for (int j = cyc - LAT; j < cyc; j++) begin
        if (j >= 0 && plan_vld[j]) exp_busy = 1'b1;
      end
      check("out_valid", 32'(out_valid), 32'(exp_v[cyc]));
      check("mag_out", 32'(mag_out), 32'(held_m));
      check("phase_out", 32'(phase_out), 32'(held_p));
      check("busy", 32'(busy), 32'(exp_busy));
      vld_in  = plan_vld[cyc];
      flip_in = plan_flip[cyc];
      x_in    = has_dat[cyc] ? dat_x[cyc] : 16'($urandom);
      z_in    = has_dat[cyc] ? dat_z[cyc] : 16'($urandom);
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    held_m   = '0;
    held_p   = '0;
    clear_plan();

`ifdef CORDIC_POST_SCALE_ROUND_EN
    tbl[0] = '{1'b0, 16'd10000, 16'h2000, 16'd6073,  16'h2000};
    tbl[1] = '{1'b1, 16'd10000, 16'h2000, 16'd6073,  16'hA000};
    tbl[2] = '{1'b1, 16'd10000, 16'h7000, 16'd6073,  16'hF000};
    tbl[3] = '{1'b0, 16'h7FFF,  16'h1234, 16'd19898, 16'h1234};
`else
    tbl[0] = '{1'b0, 16'd10000, 16'h2000, 16'd6072,  16'h2000};
    tbl[1] = '{1'b1, 16'd10000, 16'h2000, 16'd6072,  16'hA000};
    tbl[2] = '{1'b1, 16'd10000, 16'h7000, 16'd6072,  16'hF000};
    tbl[3] = '{1'b0, 16'h7FFF,  16'h1234, 16'd19897, 16'h1234};
`endif
    tbl[4] = '{1'b0, 16'hFFFB,  16'h0100, 16'd0,     16'h0100};
    tbl[5] = '{1'b0, 16'h0000,  16'hFFFF, 16'd0,     16'hFFFF};

    // Reset with vld_in held high: must be ignored.
    rst     = 1'b0;
    vld_in  = 1'b1;
    flip_in = 1'b1;
    x_in    = 16'd1234;
    z_in    = 16'h4321;
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset mag_out", 32'(mag_out), 32'd0);
    check("reset phase_out", 32'(phase_out), 32'd0);
    vld_in = 1'b0;
    rst    = 1'b1;

    // Table vectors, back to back.
    for (int i = 0; i < 6; i++) begin
      sched(2 + i, tbl[i].flip, tbl[i].x, tbl[i].z, tbl[i].mag, tbl[i].phase);
    end
    run_until(30);

    // Ramp 0..19000 on 20 consecutive cycles.
    for (int i = 0; i < 20; i++) begin
      logic        fl;
      logic [15:0] x, z;
      fl = 1'($urandom);
      x  = 16'(i * 1000);
      z  = 16'($urandom);
      sched(40 + i, fl, x, z, ref_mag(x), ref_phase(z, fl));
    end
    run_until(90);

    // Random sparse/dense traffic across the full input range.
    for (int c = 100; c < 200; c++) begin
      if ($urandom_range(1, 0) == 1) begin
        logic        fl;
        logic [15:0] x, z;
        fl = 1'($urandom);
        x  = 16'($urandom);
        z  = 16'($urandom);
        sched(c, fl, x, z, ref_mag(x), ref_phase(z, fl));
      end
    end
    run_until(230);

    // Three samples in flight, then an asynchronous reset mid-cycle.
    for (int i = 0; i < 3; i++) begin
      sched(240 + i, 1'b0, 16'd5000 + 16'(i), 16'h0123, 16'd0, 16'd0);
    end
    run_until(250);
    vld_in = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    check("async reset out_valid", 32'(out_valid), 32'd0);
    check("async reset busy", 32'(busy), 32'd0);
    check("async reset mag_out", 32'(mag_out), 32'd0);
    check("async reset phase_out", 32'(phase_out), 32'd0);
    clear_plan();
    held_m = '0;
    held_p = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc++;

    // Single sample after release: exact latency and busy window.
    sched(255, 1'b1, 16'd20000, 16'h4000, ref_mag(16'd20000), 16'hC000);
    run_until(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
